// File: rtl/fp_pkg.sv
// Floating-point helpers shared by the systolic FMAC and its output drain:
// fp32 field layout, operand classification and fp32 -> bf16 RTNE narrowing.
package fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int BF16_MAN_W = 7;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

    function automatic fp_class_t fp32_class(input logic [31:0] d);
        logic [FP32_EXP_W-1:0] e;
        logic                  man_nz;
        fp_class_t             cls;
        e      = d[30:23];
        man_nz = |d[FP32_MAN_W-1:0];
        if (e == '0)      cls = man_nz ? SUB : ZERO;
        else if (e == '1) cls = man_nz ? NAN : INF;
        else              cls = NORM;
        return cls;
    endfunction

    // Keep the top 16 bits and add one ulp when guard is set and either
    // sticky or the kept lsb is set; a mantissa carry ripples into the exponent.
    function automatic logic [15:0] fp32_to_bf16_rtne(input logic [31:0] d, input logic ftz);
        logic        rnd;
        logic [15:0] res;
        rnd = d[15] & ((|d[14:0]) | d[16]);
        res = d[31:16] + {15'd0, rnd};
        case (fp32_class(d))
            NAN:       res = BF16_QNAN | {d[31], 15'd0};
            INF, ZERO: res = d[31:16];
            SUB:       if (ftz) res = {d[31], 15'd0};
            default:   ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/psum_drain_bf16_sync_fifo.sv
// Synchronous FIFO with MSB-toggle pointers; push into a full FIFO is only
// taken alongside a pop, and a pop of an empty FIFO is ignored (no bypass).
module sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      push,
    input  logic [W-1:0]              wdata,
    input  logic                      pop,
    output logic [W-1:0]              rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/psum_drain_bf16.sv
// Column output drain: fp32 partial sums -> optional ReLU -> bf16 RTNE ->
// FIFO -> valid/ready stream framed into tiles of TILE_LEN words.
module psum_drain_bf16
    import fp_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TILE_LEN = 16,
    parameter bit FTZ      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        relu_en,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        tile_done,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam int TW = $clog2(TILE_LEN + 1);

    logic            s1_vld_q, s1_vld_d;
    logic [31:0]     s1_data_q, s1_data_d;
    logic            s1_relu_q, s1_relu_d;
    logic            s1_last_q, s1_last_d;
    fp_class_t       s1_cls_q, s1_cls_d;
    logic            s2_vld_q, s2_vld_d;
    logic [16:0]     s2_word_q, s2_word_d;
    logic [TW-1:0]   tile_cnt_q, tile_cnt_d;
    logic            ovf_q, ovf_d;

    logic [16:0]     fifo_rdata;
    logic            fifo_full, fifo_empty, pop;
    logic [AW:0]     fifo_count;
    logic [CW-1:0]   credit;
    logic            accept, relu_zero;
    logic [15:0]     rounded;

    always_comb begin
        // Every word in S1/S2 already owns a FIFO slot, so S2 can always push.
        credit     = CW'(fifo_count) + CW'(s1_vld_q) + CW'(s2_vld_q);
        in_ready   = ~fifo_full && (credit < CW'(DEPTH));
        accept     = in_valid & in_ready & ~clear;

        s1_vld_d   = accept;
        s1_data_d  = s1_data_q;
        s1_relu_d  = s1_relu_q;
        s1_last_d  = s1_last_q;
        s1_cls_d   = s1_cls_q;
        tile_cnt_d = tile_cnt_q;
        if (accept) begin
            s1_data_d  = in_data;
            s1_relu_d  = relu_en;
            s1_cls_d   = fp32_class(in_data);
            s1_last_d  = (tile_cnt_q == TW'(TILE_LEN - 1));
            tile_cnt_d = s1_last_d ? '0 : tile_cnt_q + 1'b1;
        end

        rounded    = fp32_to_bf16_rtne(s1_data_q, FTZ);
        relu_zero  = s1_relu_q & s1_data_q[31] & (s1_cls_q != NAN);
        s2_vld_d   = s1_vld_q;
        s2_word_d  = {s1_last_q, relu_zero ? 16'h0000 : rounded};

        ovf_d      = ovf_q | (in_valid & ~in_ready & ~clear);

        if (clear) begin
            s1_vld_d   = 1'b0;
            s2_vld_d   = 1'b0;
            tile_cnt_d = '0;
        end

        out_valid  = ~fifo_empty;
        out_data   = fifo_empty ? 16'h0000 : fifo_rdata[15:0];
        out_last   = ~fifo_empty & fifo_rdata[16];
        pop        = out_valid & out_ready;
        tile_done  = pop & out_last & ~clear;
        ovf_err    = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            tile_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            tile_cnt_q <= tile_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
        s1_relu_q <= s1_relu_d;
        s1_last_q <= s1_last_d;
        s1_cls_q  <= s1_cls_d;
        s2_word_q <= s2_word_d;
    end

    sync_fifo #(.W(17), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .push  (s2_vld_q),
        .wdata (s2_word_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
